pixel_word_packer: RTL

- Upstream stage of the DDR write FIFO.
- Accepts a 16-bit pixel stream in the sender clock domain and packs 8 consecutive pixels into one 128-bit word.
- Presents each word on an AXI-Stream master that drives the FIFO's sender_axis_* port directly.
- tuser marks the word that contains the first pixel of a frame. A frame start arriving mid-word discards the partial word and realigns.

---
 rtl/pixel_word_packer.sv | 108 ++++++++++
 1 files changed

// File: rtl/pixel_word_packer.sv
// Pixel word packer: gathers PIXELS_PER_WORD consecutive pixels into one wide
// word and presents it on an AXI-Stream master (feeds the DDR write FIFO).
// A frame-start pixel arriving mid-word throws the partial word away and
// realigns the word to the new frame.
//
// Ports:
//   sender_clk, sender_rstn    clock, async active-low reset
//   pix_tvalid/tready/tdata/tuser            pixel input stream
//   sender_axis_tvalid/tready/tdata/tuser    packed word output stream
//   drop_pulse                 one-cycle pulse per discarded partial word
//   drop_count                 wrapping count of discarded partial words
//
// PIXELS_PER_WORD must be a power of two in 2..16 so the slot index wraps
// naturally at its width.
module pixel_word_packer #(
  parameter int PIXEL_WIDTH     = 16,
  parameter int PIXELS_PER_WORD = 8,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                                   sender_clk,
  input  logic                                   sender_rstn,
  input  logic                                   pix_tvalid,
  output logic                                   pix_tready,
  input  logic [PIXEL_WIDTH-1:0]                 pix_tdata,
  input  logic                                   pix_tuser,
  output logic                                   sender_axis_tvalid,
  input  logic                                   sender_axis_tready,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] sender_axis_tdata,
  output logic                                   sender_axis_tuser,
  output logic                                   drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0]              drop_count
);

  localparam int IDX_W = $clog2(PIXELS_PER_WORD);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PIXELS_PER_WORD - 1);

  logic [IDX_W-1:0]                                idx;
  logic [PIXELS_PER_WORD-1:0][PIXEL_WIDTH-1:0]     acc;
  logic [PIXELS_PER_WORD-1:0][PIXEL_WIDTH-1:0]     merged;
  logic                                            pend_user;
  logic                                            last_slot;
  logic                                            xfer;
  logic                                            restart;
  logic                                            complete;

  // Only the word-completing pixel can stall: it needs the output register,
  // which is busy while a word sits there un-accepted.
  assign last_slot  = (idx == LAST);
  assign pix_tready = !(last_slot && sender_axis_tvalid && !sender_axis_tready);
  assign xfer       = pix_tvalid && pix_tready;
  // A frame start at any slot other than 0 realigns instead of completing.
  assign restart    = xfer && pix_tuser && (idx != '0);
  assign complete   = xfer && last_slot && !pix_tuser;

  // Accumulator with the incoming pixel merged in, so the completed word can
  // be registered straight into the output stage on the final transfer.
  always_comb begin
    merged      = acc;
    merged[idx] = pix_tdata;
  end

  always_ff @(posedge sender_clk or negedge sender_rstn) begin
    if (!sender_rstn) begin
      idx       <= '0;
      acc       <= '0;
      pend_user <= 1'b0;
    end else if (restart) begin
      acc       <= '0;
      acc[0]    <= pix_tdata;
      idx       <= IDX_W'(1);
      pend_user <= 1'b1;
    end else if (xfer) begin
      acc[idx] <= pix_tdata;
      idx      <= idx + 1'b1;
      if (complete)
        pend_user <= 1'b0;
      else if (idx == '0 && pix_tuser)
        pend_user <= 1'b1;
    end
  end

  // Single-stage output register; a completing word may load in the same
  // cycle the previous one handshakes, keeping tvalid high without a bubble.
  always_ff @(posedge sender_clk or negedge sender_rstn) begin
    if (!sender_rstn) begin
      sender_axis_tvalid <= 1'b0;
      sender_axis_tdata  <= '0;
      sender_axis_tuser  <= 1'b0;
    end else if (complete) begin
      sender_axis_tvalid <= 1'b1;
      sender_axis_tdata  <= merged;
      sender_axis_tuser  <= pend_user;
    end else if (sender_axis_tready) begin
      sender_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge sender_clk or negedge sender_rstn) begin
    if (!sender_rstn) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= restart;
      if (restart) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
